// File: rtl/pc_next_gen.sv
// rtl/pc_next_gen.sv - next-PC select with held redirect; return-address stack when PC_RAS_EN is defined
module pc_next_gen #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      PC_INC    = 1,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             call_valid,
  input  logic [WIDTH-1:0] call_target,
  input  logic             ret_valid,
  input  logic [WIDTH-1:0] ret_target,
  output logic [WIDTH-1:0] new_pc,
  output logic             redirect_pend,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] evt_tgt;
  logic [WIDTH-1:0] pend_tgt;
  logic [WIDTH-1:0] ras_top;
  logic             evt_valid;
  logic             ras_empty;

  // Sequential successor wraps at 2^WIDTH; the carry is dropped on purpose.
  assign seq = pc_in + WIDTH'(PC_INC);

`ifdef PC_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_sp;   // next slot to write; top of stack is ras_sp-1
  logic [PW:0]      ras_cnt;  // valid entries, saturates at RAS_DEPTH
  logic             push;
  logic             pop;

  assign ras_empty = (ras_cnt == '0);
  assign ras_top   = ras_mem[ras_sp - PW'(1)];
  // Only the winning event touches the stack: ret beats call.
  assign pop       = ret_valid && !rst;
  assign push      = call_valid && !ret_valid && !rst;

  // Stack pointer, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_sp        <= '0;
      ras_cnt       <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (pop) begin
      if (ras_empty) begin
        ras_underflow <= 1'b1;
      end else begin
        ras_sp  <= ras_sp - PW'(1);
        ras_cnt <= ras_cnt - (PW+1)'(1);
      end
    end else if (push) begin
      // When full the write slot holds the oldest entry, so advancing overwrites it.
      ras_sp <= ras_sp + PW'(1);
      if (ras_cnt == (PW+1)'(RAS_DEPTH)) begin
        ras_overflow <= 1'b1;
      end else begin
        ras_cnt <= ras_cnt + (PW+1)'(1);
      end
    end
  end

  // Return address written on every call, stalled or not.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[ras_sp] <= seq;
    end
  end
`else
  assign ras_empty     = 1'b1;
  assign ras_top       = '0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;

  // RAS_DEPTH has no effect without the stack; this empty block keeps it referenced.
  if (RAS_DEPTH < 2) begin : g_ras_depth_unused
  end
`endif

  // Event target and the next-PC priority chain.
  always_comb begin
    evt_valid = ret_valid | call_valid | br_valid;
    evt_tgt   = br_target;
    if (ret_valid) begin
      evt_tgt = ras_empty ? ret_target : ras_top;
    end else if (call_valid) begin
      evt_tgt = call_target;
    end

    new_pc = seq;
    if (rst) begin
      new_pc = RESET_VEC;
    end else if (stall) begin
      new_pc = pc_in;
    end else if (evt_valid) begin
      new_pc = evt_tgt;
    end else if (redirect_pend) begin
      new_pc = pend_tgt;
    end
  end

  // Held redirect: newest event during a stall wins; any unstalled cycle consumes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pend <= 1'b0;
      pend_tgt      <= '0;
    end else if (stall) begin
      if (evt_valid) begin
        redirect_pend <= 1'b1;
        pend_tgt      <= evt_tgt;
      end
    end else begin
      redirect_pend <= 1'b0;
    end
  end

endmodule
